uart_tx_frame: RTL and testbench

UART_TX_FRAME -- requirements
Module: uart_tx_frame

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx_frame.sv | 153 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 133 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit frame block: the parity selection
// and the transmit FSM state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit timer: counts clocks while enabled and flags the last clock of each
// line bit. Wraps to zero on that last clock so consecutive bits chain
// without a gap.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign bit_end = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Count up while enabled; clear on reset, explicit clear or bit end.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional
// parity, STOP_BITS stop bits. All outputs are registered.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int      CLK_FREQ  = 100_000_000,
    parameter int      BAUD_RATE = 115200,
    parameter int      DATA_BITS = 8,
    parameter parity_e PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iTxStart,
    input  logic [DATA_BITS-1:0] iTxByte,
    output logic                 oTxSerial,
    output logic                 oTxBusy,
    output logic                 oTxDone
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int IDX_W        = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1..2");
    end

    tx_state_e            state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_q, par_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic                 serial_n, busy_n, done_n;
    logic                 timer_en, timer_clr, bit_end;

    assign timer_en  = (state != ST_IDLE);
    assign timer_clr = (state == ST_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (iClk),
        .rst    (iRst),
        .en     (timer_en),
        .clr    (timer_clr),
        .bit_end(bit_end)
    );

    // Next-state and next-output logic; line level is computed one cycle
    // ahead so oTxSerial can come straight from a flop.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        par_n      = par_q;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        serial_n   = oTxSerial;
        busy_n     = oTxBusy;
        done_n     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                serial_n = 1'b1;
                busy_n   = 1'b0;
                if (iTxStart) begin
                    state_n    = ST_START;
                    shreg_n    = iTxByte;
                    // Parity is fixed at acceptance from the latched payload.
                    par_n      = (^iTxByte) ^ (PARITY == PAR_ODD);
                    bit_idx_n  = '0;
                    stop_idx_n = 1'b0;
                    serial_n   = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n  = ST_DATA;
                    serial_n = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_n  = ST_PARITY;
                            serial_n = par_q;
                        end else begin
                            state_n  = ST_STOP;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                        shreg_n   = shreg >> 1;
                        serial_n  = shreg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n  = ST_STOP;
                    serial_n = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        state_n  = ST_IDLE;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        serial_n = 1'b1;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n  = ST_IDLE;
                serial_n = 1'b1;
                busy_n   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any start request.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            par_q     <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            oTxSerial <= 1'b1;
            oTxBusy   <= 1'b0;
            oTxDone   <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            par_q     <= par_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            oTxSerial <= serial_n;
            oTxBusy   <= busy_n;
            oTxDone   <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench: four configurations (8N1, 8E1, 8O1, 7N2) at 10 clocks/bit,
// each output compared every cycle against hand-computed line sequences.
module tb_uart_tx_frame;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start = '0;
    logic [7:0] b0 = '0, b1 = '0, b2 = '0;
    logic [6:0] b3 = '0;
    logic [3:0] ser, bsy, dn;

    int total = 0;
    int bad   = 0;

    // Line bit j of a frame is bit j of each constant (bit 0 = start bit).
    // 8N1 0x56 : 0,0,1,1,0,1,0,1,0,1
    // 8E1 0x56 : ...,parity 0, stop 1   8O1 0x56 : ...,parity 1, stop 1
    // 7N2 0x7F : 0, seven 1s, two stop 1s
    // 8N1 0xA5 : 0,1,0,1,0,0,1,0,1,1
    logic [10:0] seq_56n = 11'h2AC;
    logic [10:0] seq_56e = 11'h4AC;
    logic [10:0] seq_56o = 11'h6AC;
    logic [10:0] seq_7f2 = 11'h3FE;
    logic [10:0] seq_a5n = 11'h34A;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) d0 (
        .iClk(clk), .iRst(rst), .iTxStart(start[0]), .iTxByte(b0),
        .oTxSerial(ser[0]), .oTxBusy(bsy[0]), .oTxDone(dn[0]));
    uart_tx_frame #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) d1 (
        .iClk(clk), .iRst(rst), .iTxStart(start[1]), .iTxByte(b1),
        .oTxSerial(ser[1]), .oTxBusy(bsy[1]), .oTxDone(dn[1]));
    uart_tx_frame #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) d2 (
        .iClk(clk), .iRst(rst), .iTxStart(start[2]), .iTxByte(b2),
        .oTxSerial(ser[2]), .oTxBusy(bsy[2]), .oTxDone(dn[2]));
    uart_tx_frame #(.CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) d3 (
        .iClk(clk), .iRst(rst), .iTxStart(start[3]), .iTxByte(b3),
        .oTxSerial(ser[3]), .oTxBusy(bsy[3]), .oTxDone(dn[3]));

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got {ser,busy,done}=%b want %b", tag, got, exp);
        end
    endtask

    // Expected {serial,busy,done} at cycle c relative to the first START cycle.
    function automatic logic [2:0] expf(input logic [10:0] seq, input int nb, input int c);
        if (c < 0)       return 3'b100;
        if (c < nb * 10) return {seq[c / 10], 2'b10};
        if (c == nb * 10) return 3'b101;
        return 3'b100;
    endfunction

    task automatic chk_all(input string pfx, input int c, input logic [2:0] e0, input logic [2:0] e1,
                           input logic [2:0] e2, input logic [2:0] e3);
        chk($sformatf("%s d0 c%0d", pfx, c), {ser[0], bsy[0], dn[0]}, e0);
        chk($sformatf("%s d1 c%0d", pfx, c), {ser[1], bsy[1], dn[1]}, e1);
        chk($sformatf("%s d2 c%0d", pfx, c), {ser[2], bsy[2], dn[2]}, e2);
        chk($sformatf("%s d3 c%0d", pfx, c), {ser[3], bsy[3], dn[3]}, e3);
    endtask

    task automatic launch();
        @(negedge clk);
        b0 = 8'h56; b1 = 8'h56; b2 = 8'h56; b3 = 7'h7F;
        start = 4'hF;
    endtask

    // Full frames on all four; optionally with ignored mid-frame requests,
    // payload changes after acceptance and a back-to-back 0xA5 on d0.
    task automatic run_frames(input string pfx, input bit extras);
        launch();
        for (int c = 0; c <= 205; c++) begin
            @(negedge clk);
            if (extras && c > 100)
                chk_all(pfx, c, expf(seq_a5n, 10, c - 101), expf(seq_56e, 11, c),
                        expf(seq_56o, 11, c), expf(seq_7f2, 10, c));
            else
                chk_all(pfx, c, expf(seq_56n, 10, c), expf(seq_56e, 11, c),
                        expf(seq_56o, 11, c), expf(seq_7f2, 10, c));
            if (c == 0) start = '0;
            if (extras) begin
                if (c == 5)   begin b0 = 8'hFF; b1 = 8'h00; b2 = 8'hFF; b3 = 7'h00; end
                if (c == 40)  start = 4'hF;
                if (c == 41)  start = '0;
                if (c == 100) begin start[0] = 1'b1; b0 = 8'hA5; end
                if (c == 101) start[0] = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset, with a start request held alongside it that must be ignored.
        start = 4'hF;
        repeat (2) @(negedge clk);
        chk_all("rst", 0, 3'b100, 3'b100, 3'b100, 3'b100);
        start = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("idle", 0, 3'b100, 3'b100, 3'b100, 3'b100);

        run_frames("frm", 1'b1);

        // Abort during the 4th data bit (cycles 40..49); start with reset is ignored.
        launch();
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            if (c < 44)
                chk_all("abort", c, expf(seq_56n, 10, c), expf(seq_56e, 11, c),
                        expf(seq_56o, 11, c), expf(seq_7f2, 10, c));
            else
                chk_all("abort", c, 3'b100, 3'b100, 3'b100, 3'b100);
            if (c == 0)  start = '0;
            if (c == 43) begin rst = 1'b1; start = 4'hF; end
            if (c == 44) begin rst = 1'b0; start = '0; end
        end

        run_frames("post", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
